// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detection and HI/LO multiply/divide busy sequencing.
//   Optional feature macro: HAZARD_PERF_EN (adds a 32-bit stall-cycle counter).
//   Ports:
//     clk, reset                          clock, synchronous active-high reset
//     ID_rs/ID_rt, ID_TuseRs/ID_TuseRt    decode operands and their Tuse (3 = unused)
//     ID_isMD                             decode holds a HI/LO instruction
//     EX_/MEM_ writeReg/timeNew/RegWrite  producer fields of the EX and MEM stages
//     EX_mdStart, EX_mdDiv                mult/div issue in EX (div when EX_mdDiv=1)
//     PC_en, IFID_en, IDEX_flush          freeze/bubble controls (combinational)
//     md_busy, md_done                    HI/LO unit busy level and completion pulse
//     stall_count                         stall cycles seen (0 without HAZARD_PERF_EN)
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic [1:0]  ID_TuseRs,
    input  logic [1:0]  ID_TuseRt,
    input  logic        ID_isMD,
    input  logic [4:0]  EX_writeReg,
    input  logic [1:0]  EX_timeNew,
    input  logic        EX_RegWrite,
    input  logic [4:0]  MEM_writeReg,
    input  logic [1:0]  MEM_timeNew,
    input  logic        MEM_RegWrite,
    input  logic        EX_mdStart,
    input  logic        EX_mdDiv,
    output logic        PC_en,
    output logic        IFID_en,
    output logic        IDEX_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_count
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic       stall_rs, stall_rt, stall_md, stall;

    // Strict Tuse < Tnew: Tnew never exceeds 3, so Tuse=3 can never stall.
    assign stall_rs = (ID_rs != 5'd0) &&
        ((EX_RegWrite  && EX_writeReg  == ID_rs && ID_TuseRs < EX_timeNew) ||
         (MEM_RegWrite && MEM_writeReg == ID_rs && ID_TuseRs < MEM_timeNew));
    assign stall_rt = (ID_rt != 5'd0) &&
        ((EX_RegWrite  && EX_writeReg  == ID_rt && ID_TuseRt < EX_timeNew) ||
         (MEM_RegWrite && MEM_writeReg == ID_rt && ID_TuseRt < MEM_timeNew));
    assign stall_md   = ID_isMD && (EX_mdStart || md_busy);
    assign stall      = stall_rs || stall_rt || stall_md;
    assign PC_en      = !stall;
    assign IFID_en    = !stall;
    assign IDEX_flush = stall;
    assign md_busy    = (state == BUSY);

    // Starts arriving while BUSY are ignored; stall_md keeps them out of EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            md_done <= 1'b0;
        end else begin
            md_done <= 1'b0;
            if (state == IDLE) begin
                if (EX_mdStart) begin
                    cnt   <= EX_mdDiv ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    state <= BUSY;
                end
            end else begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state   <= IDLE;
                    md_done <= 1'b1;
                end
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= 32'd0;
        else if (stall)
            stall_cnt <= stall_cnt + 32'd1;
    end
    assign stall_count = stall_cnt;
`else
    assign stall_count = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed checks of hazard_ctrl against a timeline model.
module tb_hazard_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, EX_writeReg, MEM_writeReg;
    logic [1:0]  ID_TuseRs, ID_TuseRt, EX_timeNew, MEM_timeNew;
    logic        ID_isMD, EX_RegWrite, MEM_RegWrite, EX_mdStart, EX_mdDiv;
    logic        PC_en, IFID_en, IDEX_flush, md_busy, md_done;
    logic [31:0] stall_count;

    hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_TuseRs(ID_TuseRs), .ID_TuseRt(ID_TuseRt),
        .ID_isMD(ID_isMD),
        .EX_writeReg(EX_writeReg), .EX_timeNew(EX_timeNew), .EX_RegWrite(EX_RegWrite),
        .MEM_writeReg(MEM_writeReg), .MEM_timeNew(MEM_timeNew), .MEM_RegWrite(MEM_RegWrite),
        .EX_mdStart(EX_mdStart), .EX_mdDiv(EX_mdDiv),
        .PC_en(PC_en), .IFID_en(IFID_en), .IDEX_flush(IDEX_flush),
        .md_busy(md_busy), .md_done(md_done), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: the HI/LO unit is a window on a cycle timeline, not a counter FSM.
    int          cyc = 0;
    int          busy_beg = -1, busy_end = -1, done_at = -1;
    logic [31:0] sc = 0;

    function automatic bit m_busy(int c);
        return c > busy_beg && c <= busy_end;
    endfunction

    function automatic bit hit(logic [4:0] r, logic [1:0] tu);
        return r != 0 &&
            ((EX_RegWrite && EX_writeReg == r && int'(tu) < int'(EX_timeNew)) ||
             (MEM_RegWrite && MEM_writeReg == r && int'(tu) < int'(MEM_timeNew)));
    endfunction

    function automatic bit m_stall();
        return hit(ID_rs, ID_TuseRs) || hit(ID_rt, ID_TuseRt) ||
               (ID_isMD && (EX_mdStart || m_busy(cyc)));
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", n, cyc, got, exp);
        end
    endtask

    task automatic zero_in();
        ID_rs = 0; ID_rt = 0; ID_TuseRs = 3; ID_TuseRt = 3; ID_isMD = 0;
        EX_writeReg = 0; EX_timeNew = 0; EX_RegWrite = 0;
        MEM_writeReg = 0; MEM_timeNew = 0; MEM_RegWrite = 0;
        EX_mdStart = 0; EX_mdDiv = 0;
    endtask

    // Compare all outputs against the model, then advance one clock edge.
    task automatic step();
        bit s;
        #1;
        s = m_stall();
        chk("pc_en", 32'(PC_en), 32'(!s));
        chk("ifid_en", 32'(IFID_en), 32'(!s));
        chk("idex_flush", 32'(IDEX_flush), 32'(s));
        chk("md_busy", 32'(md_busy), 32'(m_busy(cyc)));
        chk("md_done", 32'(md_done), 32'(cyc == done_at));
`ifdef HAZARD_PERF_EN
        chk("stall_count", stall_count, sc);
`else
        chk("stall_count", stall_count, 32'd0);
`endif
        @(posedge clk);
        if (reset) begin
            busy_beg = -1; busy_end = -1; done_at = -1; sc = 0;
        end else begin
            if (s) sc = sc + 1;
            if (EX_mdStart && !m_busy(cyc)) begin
                busy_beg = cyc;
                busy_end = cyc + (EX_mdDiv ? DC : MC);
                done_at  = busy_end + 1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    logic [31:0] sc0;

    initial begin
        zero_in();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_pc_en", 32'(PC_en), 32'd1);
        chk("rst_flush", 32'(IDEX_flush), 32'd0);
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_count", stall_count, 32'd0);
        step();
        reset = 0;
        step();

        // lw $1 in EX, consumer needs $1 next cycle
        ID_rs = 1; ID_TuseRs = 1; EX_writeReg = 1; EX_timeNew = 2; EX_RegWrite = 1;
        #1;
        chk("lw_stall_pc", 32'(PC_en), 32'd0);
        chk("lw_stall_flush", 32'(IDEX_flush), 32'd1);
        step();
        EX_RegWrite = 0; MEM_writeReg = 1; MEM_timeNew = 1; MEM_RegWrite = 1;
        #1;
        chk("lw_mem_release", 32'(IDEX_flush), 32'd0);
        step();

        // $0 never stalls; Tuse=3 never stalls
        zero_in();
        EX_writeReg = 0; EX_timeNew = 3; EX_RegWrite = 1;
        #1;
        chk("zero_reg", 32'(IDEX_flush), 32'd0);
        step();
        EX_writeReg = 5; ID_rt = 5; ID_TuseRt = 3;
        #1;
        chk("tuse3", 32'(IDEX_flush), 32'd0);
        step();

        // div at edge 0 with an MD instruction waiting in ID
        zero_in();
        ID_isMD = 1; EX_mdStart = 1; EX_mdDiv = 1;
        #1;
        chk("div_c0_flush", 32'(IDEX_flush), 32'd1);
        step();
        EX_mdStart = 0;
        for (int i = 1; i <= 12; i++) begin
            #1;
            chk("div_busy", 32'(md_busy), 32'(i <= 10));
            chk("div_done", 32'(md_done), 32'(i == 11));
            chk("div_flush", 32'(IDEX_flush), 32'(i <= 10));
            step();
        end

        // simultaneous rs hazard and MD hazard while busy: one stall
        zero_in();
        EX_mdStart = 1;
        step();
        EX_mdStart = 0; ID_isMD = 1; ID_rs = 7; ID_TuseRs = 0;
        EX_writeReg = 7; EX_timeNew = 1; EX_RegWrite = 1;
        sc0 = stall_count;
        for (int i = 0; i < 7; i++) step();
        #1;
        chk("dual_flush", 32'(IDEX_flush), 32'd1);
`ifdef HAZARD_PERF_EN
        chk("seven_stalls", stall_count - sc0, 32'd7);
`else
        chk("no_counter", stall_count, 32'd0);
`endif
        zero_in();
        while (m_busy(cyc)) step();

        // mult then reset at cycle 3
        EX_mdStart = 1;
        step();
        EX_mdStart = 0;
        step();
        step();
        reset = 1;
        step();
        reset = 0;
        #1;
        chk("rst_mid_busy", 32'(md_busy), 32'd0);
        chk("rst_mid_done", 32'(md_done), 32'd0);
        chk("rst_mid_pc", 32'(PC_en), 32'd1);
        for (int i = 0; i < 8; i++) step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 59) == 0);
            ID_rs        = 5'($urandom_range(0, 3));
            ID_rt        = 5'($urandom_range(0, 3));
            ID_TuseRs    = 2'($urandom);
            ID_TuseRt    = 2'($urandom);
            ID_isMD      = ($urandom_range(0, 3) == 0);
            EX_writeReg  = 5'($urandom_range(0, 3));
            EX_timeNew   = 2'($urandom);
            EX_RegWrite  = 1'($urandom);
            MEM_writeReg = 5'($urandom_range(0, 3));
            MEM_timeNew  = 2'($urandom);
            MEM_RegWrite = 1'($urandom);
            EX_mdStart   = !m_busy(cyc) && ($urandom_range(0, 5) == 0);
            EX_mdDiv     = 1'($urandom);
            step();
        end
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
